// File: rtl/code_lock_pkg.sv
// ============================================================================
//  Module   : code_lock_pkg
//  Purpose  : Shared state encoding, digit width and digit-select helper for
//             the multi-digit code lock.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package code_lock_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;
    localparam int MAX_CODE_W = DIGIT_W * MAX_DIGITS;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } lock_state_t;

    // Reference codes narrower than MAX_CODE_W are zero-extended by the caller.
    function automatic logic [DIGIT_W-1:0] digit_slice(
        input logic [MAX_CODE_W-1:0] code_vec,
        input logic [2:0]            sel
    );
        return code_vec[DIGIT_W*sel +: DIGIT_W];
    endfunction

endpackage : code_lock_pkg

`default_nettype wire

// File: rtl/code_lock_entry_key_press_detect.sv
// ============================================================================
//  Module   : key_press_detect
//  Purpose  : Synchronizes the raw active-low KEY and flags each falling edge
//             with a single-cycle press strobe.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_press_detect (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    // Flops reset to the released level so a reset never manufactures an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign press = ~r_sync2 & r_sync3;

endmodule : key_press_detect

`default_nettype wire

// File: rtl/code_lock_entry.sv
// ============================================================================
//  Module   : code_lock_entry
//  Purpose  : Key-clocked multi-digit code lock with failure counting.
//             Optional lockout stage is built when CODE_LOCK_LOCKOUT_EN is
//             defined; otherwise the failure count simply saturates.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module code_lock_entry
    import code_lock_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 250
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              key_n,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic [DIGIT_W*NUM_DIGITS-1:0]     code,
    output logic                              unlocked,
    output logic                              locked_out,
    output logic                              bad_entry,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digits_entered
);

    localparam int c_idx_w  = $clog2(NUM_DIGITS);
    localparam int c_fail_w = $clog2(MAX_TRIES + 1);
    localparam int c_de_w   = $clog2(NUM_DIGITS + 1);

    localparam logic [c_idx_w-1:0]  c_idx_last   = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_fail_w-1:0] c_fail_limit = c_fail_w'(MAX_TRIES);

    if ((NUM_DIGITS < 2) || (NUM_DIGITS > MAX_DIGITS) ||
        (MAX_TRIES < 1) || (MAX_TRIES > 7) || (LOCKOUT_CYCLES < 1)) begin : g_param_check
        $error("code_lock_entry: parameter out of legal range");
    end

    lock_state_t           r_state;
    logic [c_idx_w-1:0]    r_idx;
    logic                  r_mismatch;
    logic [c_fail_w-1:0]   r_fail_cnt;
    logic                  r_unlocked;
    logic                  r_bad_entry;
    logic [c_de_w-1:0]     r_digits;

    logic                  w_press;
    logic [DIGIT_W-1:0]    w_expected;
    logic                  w_miss_total;
    logic [c_fail_w-1:0]   w_fail_next;

    key_press_detect u_key_press_detect (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n),
        .press (w_press)
    );

    assign w_expected   = digit_slice(MAX_CODE_W'(code), 3'(r_idx));
    assign w_miss_total = r_mismatch | (digit_in != w_expected);
    assign w_fail_next  = r_fail_cnt + 1'b1;

`ifdef CODE_LOCK_LOCKOUT_EN
    localparam int c_timer_w = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [c_timer_w-1:0] c_timer_load = c_timer_w'(LOCKOUT_CYCLES - 1);

    logic [c_timer_w-1:0] r_timer;
    logic                 r_locked_out;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ENTRY;
            r_idx       <= '0;
            r_mismatch  <= 1'b0;
            r_fail_cnt  <= '0;
            r_unlocked  <= 1'b0;
            r_bad_entry <= 1'b0;
            r_digits    <= '0;
`ifdef CODE_LOCK_LOCKOUT_EN
            r_timer      <= '0;
            r_locked_out <= 1'b0;
`endif
        end else begin
            r_bad_entry <= 1'b0;
            case (r_state)
                ENTRY: begin
                    if (w_press) begin
                        if (r_idx != c_idx_last) begin
                            r_idx      <= r_idx + 1'b1;
                            r_mismatch <= w_miss_total;
                            r_digits   <= c_de_w'(r_idx) + c_de_w'(1);
                        end else begin
                            r_idx      <= '0;
                            r_mismatch <= 1'b0;
                            r_digits   <= '0;
                            if (!w_miss_total) begin
                                r_state    <= OPEN;
                                r_unlocked <= 1'b1;
                                r_fail_cnt <= '0;
                            end else begin
                                r_bad_entry <= 1'b1;
`ifdef CODE_LOCK_LOCKOUT_EN
                                r_fail_cnt  <= w_fail_next;
                                if (w_fail_next == c_fail_limit) begin
                                    r_state      <= LOCKOUT;
                                    r_locked_out <= 1'b1;
                                    r_timer      <= c_timer_load;
                                end
`else
                                // Without a lockout stage the count only
                                // records that the limit has been reached.
                                if (r_fail_cnt != c_fail_limit) begin
                                    r_fail_cnt <= w_fail_next;
                                end
`endif
                            end
                        end
                    end
                end

                OPEN: begin
                    if (w_press) begin
                        r_state    <= ENTRY;
                        r_unlocked <= 1'b0;
                        r_idx      <= '0;
                        r_mismatch <= 1'b0;
                        r_digits   <= '0;
                    end
                end

`ifdef CODE_LOCK_LOCKOUT_EN
                LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_state      <= ENTRY;
                        r_locked_out <= 1'b0;
                        r_fail_cnt   <= '0;
                        r_idx        <= '0;
                        r_mismatch   <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
`endif

                default: begin
                    r_state    <= ENTRY;
                    r_idx      <= '0;
                    r_mismatch <= 1'b0;
                    r_unlocked <= 1'b0;
                    r_digits   <= '0;
                end
            endcase
        end
    end

    assign unlocked       = r_unlocked;
    assign bad_entry      = r_bad_entry;
    assign digits_entered = r_digits;

`ifdef CODE_LOCK_LOCKOUT_EN
    assign locked_out = r_locked_out;
`else
    assign locked_out = 1'b0;
`endif

endmodule : code_lock_entry

`default_nettype wire

// File: tb/tb_code_lock_entry.sv
// ============================================================================
//  Module   : tb_code_lock_entry
//  Purpose  : Directed self-checking bench for code_lock_entry (4 digits,
//             MAX_TRIES=3, LOCKOUT_CYCLES=10).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_code_lock_entry;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_n = 1'b1;
    logic [3:0]  digit_in = 4'h0;
    logic [15:0] code = 16'h7A21;
    logic        unlocked;
    logic        locked_out;
    logic        bad_entry;
    logic [2:0]  digits_entered;

    int compared   = 0;
    int mismatched = 0;
    int bad_count  = 0;
    int lo_count   = 0;
    int base_bad;
    int base_lo;
    int unl_falls;
    int de_nonzero;

    logic       pre_unl;
    logic       obs_unl;
    logic       obs_bad;
    logic       obs_bad_next;
    logic       obs_lo;
    logic [2:0] obs_de;

    code_lock_entry #(
        .NUM_DIGITS     (4),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .key_n          (key_n),
        .digit_in       (digit_in),
        .code           (code),
        .unlocked       (unlocked),
        .locked_out     (locked_out),
        .bad_entry      (bad_entry),
        .digits_entered (digits_entered)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bad_entry === 1'b1) bad_count++;
        if (locked_out === 1'b1) lo_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        key_n = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Falling key edge at a negedge; the FSM acts on the third posedge after.
    task automatic press(input logic [3:0] d);
        @(negedge clk);
        digit_in = d;
        key_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pre_unl = unlocked;
        @(negedge clk);
        obs_unl = unlocked;
        obs_bad = bad_entry;
        obs_lo  = locked_out;
        obs_de  = digits_entered;
        key_n   = 1'b1;
        @(negedge clk);
        obs_bad_next = bad_entry;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic enter4(input logic [15:0] digs);
        for (int i = 0; i < 4; i++) begin
            press(digs[4*i +: 4]);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_unlocked", {31'd0, unlocked}, 32'd0);
        chk("reset_locked_out", {31'd0, locked_out}, 32'd0);
        chk("reset_bad_entry", {31'd0, bad_entry}, 32'd0);
        chk("reset_digits", {29'd0, digits_entered}, 32'd0);

        // Correct entry 1,2,A,7
        base_bad = bad_count;
        press(4'h1);
        chk("ok_d1_digits", {29'd0, obs_de}, 32'd1);
        press(4'h2);
        chk("ok_d2_digits", {29'd0, obs_de}, 32'd2);
        press(4'hA);
        chk("ok_d3_digits", {29'd0, obs_de}, 32'd3);
        press(4'h7);
        chk("ok_latency_pre", {31'd0, pre_unl}, 32'd0);
        chk("ok_unlocked", {31'd0, obs_unl}, 32'd1);
        chk("ok_digits_open", {29'd0, obs_de}, 32'd0);
        chk("ok_no_bad", bad_count - base_bad, 32'd0);

        // Hold key in OPEN: one relock, no repeats
        unl_falls  = 0;
        de_nonzero = 0;
        @(negedge clk);
        digit_in = 4'h1;
        key_n    = 1'b0;
        for (int i = 0; i < 50; i++) begin
            logic prev;
            prev = unlocked;
            @(negedge clk);
            if (prev && !unlocked) unl_falls++;
            if (digits_entered != 3'd0) de_nonzero++;
        end
        key_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("hold_one_relock", unl_falls, 32'd1);
        chk("hold_unlocked", {31'd0, unlocked}, 32'd0);
        chk("hold_digits_zero", de_nonzero, 32'd0);

        // Wrong entry 1,2,B,7
        base_bad = bad_count;
        press(4'h1);
        press(4'h2);
        press(4'hB);
        chk("bad_d3_digits", {29'd0, obs_de}, 32'd3);
        press(4'h7);
        chk("bad_pulse", {31'd0, obs_bad}, 32'd1);
        chk("bad_pulse_end", {31'd0, obs_bad_next}, 32'd0);
        chk("bad_unlocked", {31'd0, obs_unl}, 32'd0);
        chk("bad_digits", {29'd0, obs_de}, 32'd0);
        chk("bad_count_one", bad_count - base_bad, 32'd1);

`ifdef CODE_LOCK_LOCKOUT_EN
        do_reset();
        base_lo = lo_count;
        enter4(16'h7A20);
        chk("lo_after1", {31'd0, obs_lo}, 32'd0);
        enter4(16'h7A20);
        chk("lo_after2", {31'd0, obs_lo}, 32'd0);
        enter4(16'h7A20);
        chk("lo_enter", {31'd0, obs_lo}, 32'd1);
        press(4'h1);
        chk("lo_press_ignored_lo", {31'd0, obs_lo}, 32'd1);
        chk("lo_press_ignored_de", {29'd0, obs_de}, 32'd0);
        repeat (3) @(negedge clk);
        chk("lo_released", {31'd0, locked_out}, 32'd0);
        chk("lo_cycles", lo_count - base_lo, 32'd10);
        chk("lo_digits_after", {29'd0, digits_entered}, 32'd0);
        enter4(16'h7A21);
        chk("lo_then_open", {31'd0, obs_unl}, 32'd1);
`else
        do_reset();
        base_bad = bad_count;
        base_lo  = lo_count;
        for (int k = 0; k < 5; k++) begin
            enter4(16'h7A20);
        end
        chk("nolo_locked_out", {31'd0, locked_out}, 32'd0);
        chk("nolo_lo_cycles", lo_count - base_lo, 32'd0);
        chk("nolo_bad_pulses", bad_count - base_bad, 32'd5);
        enter4(16'h7A21);
        chk("nolo_then_open", {31'd0, obs_unl}, 32'd1);
`endif

        // Reset coinciding with a press mid-entry
        do_reset();
        press(4'h1);
        press(4'h2);
        chk("rst_pre_digits", {29'd0, obs_de}, 32'd2);
        @(negedge clk);
        digit_in = 4'hA;
        key_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        key_n = 1'b1;
        chk("rst_digits", {29'd0, digits_entered}, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_digits_later", {29'd0, digits_entered}, 32'd0);
        chk("rst_unlocked", {31'd0, unlocked}, 32'd0);
        enter4(16'h7A21);
        chk("rst_then_open", {31'd0, obs_unl}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_code_lock_entry

`default_nettype wire
